pipelined_adder_nbit: RTL and testbench



---
 rtl/pipelined_adder_nbit_pkg.sv | 21 ++
 rtl/pipelined_adder_nbit_adder_slice.sv | 48 ++++
 rtl/pipelined_adder_nbit.sv | 176 +++++++++++++++++
 tb/tb_pipelined_adder_nbit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_nbit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder_nbit_pkg
//  Brief    : Shared ULA definitions: operation encoding and the parameter
//             legality check used by the pipelined adder.
//  Revision : 1.0 - initial release
// ============================================================================
package pipelined_adder_nbit_pkg;

  // Operation select encoding for the Op input
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // True when the width can be split into equal slices, one per stage
  function automatic bit params_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) &&
           ((width % stages) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_adder_nbit_adder_slice.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder / adder_slice
//  Brief    : 1-bit full adder cell and the SW-bit ripple slice built from it.
//             The slice also exposes the carry into its MSB so the last
//             stage can derive signed overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_cin,
  output logic [SW-1:0] o_sum,
  output logic          o_cout,
  output logic          o_c_msb
);
  // w_carry[i] is the carry into bit i; w_carry[SW] leaves the slice
  logic [SW:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar i = 0; i < SW; i++) begin : g_bit
    full_adder u_fa (
      .i_a (i_a[i]),
      .i_b (i_b[i]),
      .i_c (w_carry[i]),
      .o_s (o_sum[i]),
      .o_c (w_carry[i+1])
    );
  end

  assign o_cout  = w_carry[SW];
  assign o_c_msb = w_carry[SW-1];
endmodule
`default_nettype wire

// File: rtl/pipelined_adder_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder_nbit
//  Brief    : WIDTH-bit two's-complement adder/subtractor split into STAGES
//             carry-chained slices, one slice per clock, with a valid/ready
//             handshake that freezes the whole pipe on backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder_nbit
  import pipelined_adder_nbit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);

  localparam int SW = WIDTH / STAGES;

  if (!params_ok(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_adder_nbit: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // Single advance enable: every stage moves together or holds together
  logic             w_adv;
  logic [WIDTH-1:0] w_b_in0;
  logic             w_c_in0;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Subtraction is A + ~B + 1; Cin only matters for addition
  assign w_b_in0 = (Op == OP_SUB) ? ~B : B;
  assign w_c_in0 = (Op == OP_ADD) ? Cin : 1'b1;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still unconsumed on entry, and result bits known on exit
    localparam int IN_W   = WIDTH - k * SW;
    localparam int DONE_W = (k + 1) * SW;

    logic [IN_W-1:0]   w_a_in;
    logic [IN_W-1:0]   w_b_in;
    logic              w_c_in;
    logic              w_vld_in;
    logic [SW-1:0]     w_slice_sum;
    logic              w_slice_cout;
    logic              w_slice_cmsb;
    logic [DONE_W-1:0] w_sum_next;

    logic [DONE_W-1:0] sum_d, sum_q;
    logic              cout_d, cout_q;
    logic              vld_d, vld_q;

    if (k == 0) begin : g_head
      assign w_a_in     = A;
      assign w_b_in     = w_b_in0;
      assign w_c_in     = w_c_in0;
      assign w_vld_in   = in_valid;
      assign w_sum_next = w_slice_sum;
    end else begin : g_body
      assign w_a_in     = g_stage[k-1].g_fwd.a_q;
      assign w_b_in     = g_stage[k-1].g_fwd.b_q;
      assign w_c_in     = g_stage[k-1].cout_q;
      assign w_vld_in   = g_stage[k-1].vld_q;
      assign w_sum_next = {w_slice_sum, g_stage[k-1].sum_q};
    end

    adder_slice #(.SW(SW)) u_slice (
      .i_a     (w_a_in[SW-1:0]),
      .i_b     (w_b_in[SW-1:0]),
      .i_cin   (w_c_in),
      .o_sum   (w_slice_sum),
      .o_cout  (w_slice_cout),
      .o_c_msb (w_slice_cmsb)
    );

    // Load the partial result, slice carry and valid bit, or hold on stall
    always_comb begin
      sum_d  = sum_q;
      cout_d = cout_q;
      vld_d  = vld_q;
      if (w_adv) begin
        sum_d  = w_sum_next;
        cout_d = w_slice_cout;
        vld_d  = w_vld_in;
      end
    end

    // Stage result registers; reset clears every in-flight beat
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q  <= '0;
        cout_q <= 1'b0;
        vld_q  <= 1'b0;
      end else begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        vld_q  <= vld_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Upper operand slices travel alongside the beat until consumed
      localparam int FWD_W = IN_W - SW;

      logic [FWD_W-1:0] a_d, a_q;
      logic [FWD_W-1:0] b_d, b_q;

      // Forward the not-yet-added operand bits, or hold on stall
      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (w_adv) begin
          a_d = w_a_in[IN_W-1:SW];
          b_d = w_b_in[IN_W-1:SW];
        end
      end

      // Operand skew registers
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_tail
      logic ovf_d, ovf_q;
      logic zero_d, zero_q;

      // Flags come from the fully assembled result in the final stage
      always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (w_adv) begin
          ovf_d  = w_slice_cmsb ^ w_slice_cout;
          zero_d = (w_sum_next == '0);
        end
      end

      // Flag registers, aligned with the final Sum and Cout
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign Sum       = g_stage[STAGES-1].sum_q;
  assign Cout      = g_stage[STAGES-1].cout_q;
  assign Overflow  = g_stage[STAGES-1].g_tail.ovf_q;
  assign Zero      = g_stage[STAGES-1].g_tail.zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_adder_nbit
//  Brief    : Self-checking bench for pipelined_adder_nbit (WIDTH=8,
//             STAGES=4) against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder_nbit;

  localparam int WIDTH  = 8;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;
  logic             Zero;

  pipelined_adder_nbit #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Op        (Op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Overflow  (Overflow),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          n_acc  = 0;
  bit          lat_mode;
  bit          held   = 1'b0;
  logic [10:0] held_val;

  // Reference: plain integer arithmetic on the operation's meaning
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic op);
    exp_t e;
    int   full;
    int   sres;
    int   sa;
    int   sb;
    sa = $signed(a);
    sb = $signed(b);
    if (op) begin
      full = int'(a) + (255 - int'(b)) + 1;
      sres = sa - sb;
    end else begin
      full = int'(a) + int'(b) + int'(cin);
      sres = sa + sb + int'(cin);
    end
    e.sum  = full[7:0];
    e.cout = full[8];
    e.ovf  = (sres > 127) || (sres < -128);
    e.zero = (full[7:0] == 8'h00);
    e.cyc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: observe at the falling edge, then step past the rising edge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
    if (held)
      check("stall_hold", {20'b0, out_valid, Sum, Cout, Overflow, Zero}, {20'b0, 1'b1, held_val});
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", {31'b0, out_valid}, 32'd0);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        check("sum",      {24'b0, Sum},      {24'b0, e.sum});
        check("cout",     {31'b0, Cout},     {31'b0, e.cout});
        check("overflow", {31'b0, Overflow}, {31'b0, e.ovf});
        check("zero",     {31'b0, Zero},     {31'b0, e.zero});
        if (e.lat) check("latency", cyc - e.cyc, STAGES);
      end
    end
    held     = out_valid && !out_ready;
    held_val = {Sum, Cout, Overflow, Zero};
    if (in_valid && in_ready) begin
      e     = model(A, B, Cin, Op);
      e.cyc = cyc;
      e.lat = lat_mode;
      exp_q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic op);
    in_valid = 1'b1;
    A        = a;
    B        = b;
    Cin      = cin;
    Op       = op;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    Op        = 1'b0;
    lat_mode  = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum",       {24'b0, Sum},       32'd0);
    check("rst_cout",      {31'b0, Cout},      32'd0);
    check("rst_overflow",  {31'b0, Overflow},  32'd0);
    check("rst_zero",      {31'b0, Zero},      32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases, issued back-to-back
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    send(8'h05, 8'h05, 1'b1, 1'b1);
    send(8'h00, 8'h01, 1'b0, 1'b1);
    send(8'hFF, 8'h00, 1'b1, 1'b0);
    idle(6);
    check("directed_drain", exp_q.size(), 32'd0);

    // Back-to-back random beats at full throughput
    for (int i = 0; i < 16; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    idle(6);
    check("b2b_drain", exp_q.size(), 32'd0);

    // Reset while beats are in flight and one sits at the output
    for (int i = 0; i < 5; i++)
      send(8'(8'h11 * i + 1), 8'h10, 1'b0, 1'b0);
    check("pre_reset_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_sum",       {24'b0, Sum},       32'd0);
    check("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    exp_q.delete();
    held = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(8);

    // Randomised valid/ready backpressure
    lat_mode = 1'b0;
    n_acc    = 0;
    for (int guard = 0; guard < 20000 && n_acc < 1000; guard++) begin
      in_valid  = 1'($urandom);
      A         = 8'($urandom);
      B         = 8'($urandom);
      Cin       = 1'($urandom);
      Op        = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    check("bp_accepted", n_acc, 32'd1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) cycle();
    check("bp_drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
